uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Two-requester round-robin arbiter that shares the single `sendUART` transmitter between the `main` datapath (`UART_BYTE_OUT`/`UART_START_SEND`) and a second byte source, such as a return-value reporter. Each requester has a one-byte holding register. The arbiter issues one byte at a time to `sendUART`, waits for its `finish`, and returns a per-requester done pulse. A watchdog aborts a transfer when `finish` never arrives.

## Interface
Parameters:
- `TIMEOUT`, 8192: cycles to wait for `tx_finish` after issue before aborting. Must be ≥ 2.
- `CNT_W`, 14: watchdog counter width. Must satisfy 2^`CNT_W` ≥ `TIMEOUT`.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset).
- `req0_start`, in, 1: one-cycle pulse from requester 0 offering `req0_byte`.
- `req0_byte`, in, 8: data byte, sampled in the `req0_start` cycle.
- `req0_busy`, out, 1: requester 0 holding register occupied.
- `req0_done`, out, 1: one-cycle pulse when requester 0's byte has completed or aborted.
- `req0_err`, out, 1: one-cycle pulse together with `req0_done` when the transfer aborted on timeout.
- `req0_drop`, out, 1: one-cycle pulse when a `req0_start` was rejected because the holder was full.
- `req1_start`, `req1_byte`, `req1_busy`, `req1_done`, `req1_err`, `req1_drop`: same as above, for requester 1.
- `tx_start`, out, 1: one-cycle start pulse to `sendUART`.
- `tx_byte`, out, 8: byte to `sendUART`. Stable from the `tx_start` cycle until the transfer ends.
- `tx_finish`, in, 1: completion from `sendUART`. Level or pulse; sampled only in WAIT.

## Operation
- Per requester `i`, there is a holding register `hold_i[7:0]` and a flag `pend_i`. `reqi_busy = pend_i`.
- Accept rule: `reqi_start` is accepted when `pend_i`=0, or when the arbiter is in DONE with `grant`=`i`.
  - On accept: `hold_i` ← `reqi_byte` and `pend_i` ← 1 at the next edge.
  - Set wins over the DONE clear in the same cycle.
- Reject rule: if `reqi_start` arrives and the accept rule fails, the byte is discarded and `reqi_drop` pulses the following cycle.
- Round-robin: the `last` register holds the most recently served requester.
  - In IDLE with both `pend` set, grant `~last`; otherwise grant whichever `pend` is set.
  - `last` resets to 1, so requester 0 wins the first tie.
- State machine (`state`, `grant`, `cnt`):
  - IDLE: if any `pend`, latch `grant` and go to ISSUE; else stay.
  - ISSUE: `tx_start`=1 for exactly this cycle; `cnt` ← 0; go to WAIT.
  - WAIT: `cnt` increments each cycle.
    - If `tx_finish`=1, go to DONE with `abort`=0.
    - Else if `cnt` = `TIMEOUT`-1, go to DONE with `abort`=1.
    - Else stay in WAIT.
    - `tx_finish` wins if both conditions hold in the same cycle.
  - DONE: `req{grant}_done`=1; `req{grant}_err`=`abort`; `pend_grant` ← 0 (unless re-accepted); `last` ← `grant`; go to IDLE.
- `tx_byte` = `hold_grant` during ISSUE, WAIT and DONE; otherwise 0.
- `tx_finish` outside WAIT is ignored. A `finish` that is still high from the prior byte is not sampled until the next WAIT, which begins at least 2 cycles later.

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE, `grant`=0, `last`=1, `cnt`=0, `pend`=0, `abort`=0, `hold`=0. All outputs are 0 while reset is held and in the first cycle after release.
- Reset mid-transfer abandons the byte without a done pulse. `sendUART` shares the same reset.
- Latency when idle: `reqi_start` in cycle 0 → `pend_i`=1 and IDLE sees it in cycle 1 → `tx_start`=1 in cycle 2.
- `tx_finish` seen in WAIT cycle n → `reqi_done` in cycle n+1 → IDLE in n+2 → next `tx_start` in n+3.
  - This gives 3 dead cycles between bytes.
- Timeout: `tx_start` in cycle t → `cnt` reaches `TIMEOUT`-1 in cycle t+`TIMEOUT` → `done`/`err` in cycle t+`TIMEOUT`+1.
- Simultaneous `req0_start` and `req1_start` while idle: both are accepted. Requester 0 is sent first after reset (`last`=1); requester 1 follows.
- Outputs are registered or decoded from state. There is no combinational path from any `req*` input to `tx_*`.

## Test plan
- Single byte: `req0_start` with 0xA5 at cycle 0 → `tx_start` at cycle 2 with `tx_byte`=0xA5. Drive `tx_finish` at cycle 10 → `req0_done` at 11, `req0_err`=0, `req0_busy` low at 12.
- Tie plus fairness: both starts in the same cycle (0x11, 0x22) → 0x11 sent first, then 0x22. Repeat the tie → 0x11 first again, since `last`=1 after serving requester 1. A continuous pair of streams alternates 0,1,0,1.
- Overflow: `req1_start` 0x33, then `req1_start` 0x44 while `req1_busy`=1 → `req1_drop` pulse; only 0x33 is transmitted.
- Back-to-back: `req0_start` 0x55 in the DONE cycle of requester 0's prior byte → accepted with no drop; `req0_busy` stays 1; 0x55 issued 2 cycles later.
- Timeout: `TIMEOUT`=16, `tx_finish` never asserted → `req0_done` and `req0_err` 17 cycles after `tx_start`. Boundary: `tx_finish` at `cnt`=15 → `err`=0.
- Reset mid-WAIT: pull `reset` low asynchronously between edges → outputs 0 immediately. No `done` pulse ever appears; after release, a new request completes normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one sendUART transmitter between two byte sources. Each source
// owns a one-byte holding register. A round-robin FSM issues one held byte
// at a time, waits for the transmitter's finish, and then returns a done
// pulse to the requester that owned the byte. A watchdog aborts a transfer
// whose finish never arrives and flags the abort with an err pulse.
//
// Parameters:
//   TIMEOUT  cycles to wait for tx_finish after issue before aborting (>= 2)
//   CNT_W    watchdog counter width, 2**CNT_W >= TIMEOUT
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous reset, active low
//   reqN_start/_byte    one-cycle offer of a byte from requester N
//   reqN_busy           requester N holding register occupied
//   reqN_done           one-cycle pulse when requester N's byte completed or aborted
//   reqN_err            one-cycle pulse with reqN_done when the transfer timed out
//   reqN_drop           one-cycle pulse when an offer was rejected (holder full)
//   tx_start            one-cycle start pulse to sendUART
//   tx_byte             byte to sendUART, stable from tx_start to end of transfer
//   tx_finish           completion from sendUART, sampled only while waiting

module uart_tx_arbiter #(
    parameter int TIMEOUT = 8192,
    parameter int CNT_W   = 14
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       req0_start,
    input  logic [7:0] req0_byte,
    output logic       req0_busy,
    output logic       req0_done,
    output logic       req0_err,
    output logic       req0_drop,

    input  logic       req1_start,
    input  logic [7:0] req1_byte,
    output logic       req1_busy,
    output logic       req1_done,
    output logic       req1_err,
    output logic       req1_drop,

    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_finish
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic             grant, grant_next;
    logic             last, last_next;
    logic             abort, abort_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [7:0]       hold0, hold1;
    logic             pend0, pend1;
    logic             drop0, drop1;

    logic             release0, release1;
    logic             accept0, accept1;

    // The DONE cycle frees the granted holder; a new offer from the same
    // requester in that cycle is allowed to refill it (back-to-back bytes).
    assign release0 = (state == DONE) && !grant;
    assign release1 = (state == DONE) &&  grant;
    assign accept0  = req0_start && (!pend0 || release0);
    assign accept1  = req1_start && (!pend1 || release1);

    // Holding registers, pending flags and registered drop pulses.
    // A set from an accepted offer takes priority over the DONE clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold0 <= 8'h00;
            hold1 <= 8'h00;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            drop0 <= 1'b0;
            drop1 <= 1'b0;
        end else begin
            drop0 <= req0_start && !accept0;
            drop1 <= req1_start && !accept1;

            if (accept0) begin
                hold0 <= req0_byte;
                pend0 <= 1'b1;
            end else if (release0) begin
                pend0 <= 1'b0;
            end

            if (accept1) begin
                hold1 <= req1_byte;
                pend1 <= 1'b1;
            end else if (release1) begin
                pend1 <= 1'b0;
            end
        end
    end

    // FSM and watchdog state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            abort <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
            abort <= abort_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. On a tie the requester not served last wins; with
    // last reset to 1, requester 0 wins the first tie. A finish seen in the
    // same cycle as the watchdog limit counts as a normal completion.
    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        abort_next = abort;
        cnt_next   = cnt;

        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    grant_next = (pend0 && pend1) ? ~last : pend1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt + CNT_ONE;
                if (tx_finish) begin
                    abort_next = 1'b0;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    abort_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                last_next  = grant;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs come from registers or from decoded state, so no request
    // input reaches the transmitter side combinationally.
    assign tx_start  = (state == ISSUE);
    assign tx_byte   = (state != IDLE) ? (grant ? hold1 : hold0) : 8'h00;

    assign req0_busy = pend0;
    assign req1_busy = pend1;
    assign req0_done = release0;
    assign req1_done = release1;
    assign req0_err  = release0 && abort;
    assign req1_err  = release1 && abort;
    assign req0_drop = drop0;
    assign req1_drop = drop1;

endmodule
